// File: rtl/modular_square_final_norm_if.sv
// rtl/modular_square_final_norm_if.sv - load/accumulate/normalize bus for the final normalization stage
//
// Ports (signals):
//   load_sq_in, sq_in          : load an initial square into the word registers
//   acc_valid, acc_sum_terms   : column sums from the reduction stage
//   normalize_req              : request full carry propagation
//   sq_out, sq_out_valid       : word registers and their stability flag
//   norm_busy, norm_done       : normalization in progress / completion pulse
// Modports: master drives requests and data, slave is the normalization block.
interface modular_square_final_norm_if #(
    parameter int NUM_ELEMENTS = 21,
    parameter int WORD_LEN     = 50,
    parameter int ACC_BIT_LEN  = 58
);
    logic                                        load_sq_in;
    logic [NUM_ELEMENTS-1:0][WORD_LEN:0]         sq_in;
    logic                                        acc_valid;
    logic [NUM_ELEMENTS-1:0][ACC_BIT_LEN-1:0]    acc_sum_terms;
    logic                                        normalize_req;
    logic [NUM_ELEMENTS-1:0][WORD_LEN:0]         sq_out;
    logic                                        sq_out_valid;
    logic                                        norm_busy;
    logic                                        norm_done;

    modport master (
        output load_sq_in, sq_in, acc_valid, acc_sum_terms, normalize_req,
        input  sq_out, sq_out_valid, norm_busy, norm_done
    );

    modport slave (
        input  load_sq_in, sq_in, acc_valid, acc_sum_terms, normalize_req,
        output sq_out, sq_out_valid, norm_busy, norm_done
    );
endinterface

// File: rtl/modular_square_final_norm.sv
// rtl/modular_square_final_norm.sv - redundant-word register with accumulate and sequential carry normalization
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset (wins over ce)
//   ce    : clock enable; low freezes every register including status outputs
//   bus   : modular_square_final_norm_if.slave (load / accumulate / normalize / result)
//
// Each word is WORD_LEN+1 bits: WORD_LEN canonical bits plus one carry bit.
// The top word only keeps TOP_REG_LEN bits; it is stored zero-padded so sq_out
// can expose it directly. Normalization ripples one carry per ce cycle from
// word 0 upwards, taking NUM_ELEMENTS-1 cycles, then pulses norm_done.
module modular_square_final_norm #(
    parameter int NUM_ELEMENTS = 21,
    parameter int WORD_LEN     = 50,
    parameter int ACC_BIT_LEN  = 58,
    parameter int TOP_REG_LEN  = 33
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ce,
    modular_square_final_norm_if.slave    bus
);
    localparam int W1  = WORD_LEN + 1;
    localparam int K_W = $clog2(NUM_ELEMENTS);
    localparam int TOP = NUM_ELEMENTS - 1;

    // Keeps the low TOP_REG_LEN bits of a word; applied to every top-word write.
    localparam logic [WORD_LEN:0] TOP_MASK = {W1{1'b1}} >> (W1 - TOP_REG_LEN);
    localparam logic [K_W-1:0]    LAST_K   = K_W'(NUM_ELEMENTS - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [K_W-1:0]    k;
    logic [WORD_LEN:0] words      [NUM_ELEMENTS];
    logic [WORD_LEN:0] load_words [NUM_ELEMENTS];
    logic [WORD_LEN:0] acc_words  [NUM_ELEMENTS];
    logic [WORD_LEN:0] norm_words [NUM_ELEMENTS];
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    // The carry bits of the topmost column sum have no word above them.
    logic              unused_top_carry;
    assign unused_top_carry = ^bus.acc_sum_terms[TOP][ACC_BIT_LEN-1:WORD_LEN];

    always_comb begin
        for (int e = 0; e < NUM_ELEMENTS; e++) begin
            load_words[e] = bus.sq_in[e];
        end
        load_words[TOP] = bus.sq_in[TOP] & TOP_MASK;
    end

    // Column e keeps its low WORD_LEN bits and absorbs the overflow of column e-1.
    always_comb begin
        for (int e = 0; e < NUM_ELEMENTS; e++) begin
            acc_words[e] = W1'(bus.acc_sum_terms[e][WORD_LEN-1:0]);
        end
        for (int e = 1; e < NUM_ELEMENTS; e++) begin
            acc_words[e] = acc_words[e]
                         + W1'(bus.acc_sum_terms[e-1][ACC_BIT_LEN-1:WORD_LEN]);
        end
        acc_words[TOP] = acc_words[TOP] & TOP_MASK;
    end

    // One ripple step at index k: clear word k's carry bit and add it into word k+1.
    always_comb begin
        for (int e = 0; e < NUM_ELEMENTS; e++) begin
            norm_words[e] = words[e];
            if (K_W'(e) == k) begin
                norm_words[e] = {1'b0, words[e][WORD_LEN-1:0]};
            end
        end
        for (int e = 1; e < NUM_ELEMENTS; e++) begin
            if (K_W'(e - 1) == k) begin
                norm_words[e] = words[e] + W1'(words[e-1][WORD_LEN]);
            end
        end
        norm_words[TOP] = norm_words[TOP] & TOP_MASK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < NUM_ELEMENTS; e++) begin
                words[e] <= '0;
            end
            state   <= IDLE;
            k       <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ce) begin
            if (bus.load_sq_in) begin
                // A load aborts any normalization in flight without a done pulse.
                words   <= load_words;
                state   <= IDLE;
                k       <= '0;
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.acc_valid) begin
                            words   <= acc_words;
                            valid_q <= 1'b1;
                        end else if (bus.normalize_req) begin
                            state   <= NORM;
                            k       <= '0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                        done_q <= 1'b0;
                    end
                    NORM: begin
                        words <= norm_words;
                        if (k == LAST_K) begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        k       <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int e = 0; e < NUM_ELEMENTS; e++) begin
            bus.sq_out[e] = words[e];
        end
    end

    assign bus.sq_out_valid = valid_q;
    assign bus.norm_busy    = busy_q;
    assign bus.norm_done    = done_q;
endmodule
